inbuf_loader: RTL

//  Tile sequencer around the per-row input FIFOs of the systolic array. Upstream side:

---
 rtl/systola_pkg.sv | 18 +
 rtl/skew_gen.sv | 18 +
 rtl/inbuf_loader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/systola_pkg.sv
// Shared types and helpers for the systolic-array input side.
package systola_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        DRAIN
    } ldr_state_t;

    // True while drain count cnt lies inside row r's read window of k words.
    function automatic logic skew_win(input int unsigned r,
                                      input int unsigned cnt,
                                      input int unsigned k);
        return (r <= cnt) && (cnt < r + k);
    endfunction

endpackage

// File: rtl/skew_gen.sv
// Skewed read-strobe generator: row r pops its buffer for k cycles starting r cycles into the drain.
module skew_gen
    import systola_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int TILE_K = 8,
    parameter int CW     = 4
) (
    input  logic            en,
    input  logic [CW-1:0]   drain_cnt,
    output logic [ROWS-1:0] rd
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign rd[r] = en && skew_win(r, 32'(drain_cnt), TILE_K);
    end

endmodule

// File: rtl/inbuf_loader.sv
// Tile sequencer for the per-row input FIFOs: broadcasts TILE_K column vectors into every
// buffer, then drains them diagonally so operands enter the array skewed by row.
//
//   state  | meaning
//   IDLE   | waiting for start; upstream not ready
//   LOAD   | accepting TILE_K beats, each written to all buffers one cycle later
//   SETTLE | last registered write lands in the buffers
//   DRAIN  | skewed reads, TILE_K+ROWS-1 cycles, done on the final one
module inbuf_loader
    import systola_pkg::*;
#(
    parameter int WORDLEN = 8,
    parameter int ROWS    = 4,
    parameter int BUFSIZE = 16,
    parameter int TILE_K  = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [ROWS*WORDLEN-1:0] s_data,
    output logic [ROWS-1:0]         buf_write,
    output logic [ROWS*WORDLEN-1:0] buf_din,
    output logic [ROWS-1:0]         buf_read,
    output logic [ROWS-1:0]         arr_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int BW = $clog2(TILE_K + 1);
    localparam int DW = $clog2(TILE_K + ROWS);
    localparam logic [BW-1:0] LAST_BEAT  = BW'(TILE_K - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(TILE_K + ROWS - 2);

    // A tile must fit in a buffer with one slot to spare.
    if (TILE_K < 1 || TILE_K > BUFSIZE - 1) begin : g_bad_tile_k
        $error("inbuf_loader: TILE_K must be in 1..BUFSIZE-1");
    end

    ldr_state_t               state_q, state_d;
    logic [BW-1:0]            beat_cnt_q, beat_cnt_d;
    logic [DW-1:0]            drain_cnt_q, drain_cnt_d;
    logic                     wr_q, wr_d;
    logic [ROWS*WORDLEN-1:0]  din_q, din_d;
    logic                     beat;

    assign s_ready = (state_q == LOAD);
    assign beat    = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        wr_d        = beat;
        din_d       = beat ? s_data : din_q;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    beat_cnt_d = '0;
                end
            end
            LOAD: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                state_d     = DRAIN;
                drain_cnt_d = '0;
            end
            DRAIN: begin
                if (drain_cnt_q == LAST_DRAIN) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            wr_q        <= 1'b0;
            din_q       <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            wr_q        <= wr_d;
            din_q       <= din_d;
        end
    end

    skew_gen #(
        .ROWS   (ROWS),
        .TILE_K (TILE_K),
        .CW     (DW)
    ) u_skew_gen (
        .en        (state_q == DRAIN),
        .drain_cnt (drain_cnt_q),
        .rd        (buf_read)
    );

    assign buf_write = {ROWS{wr_q}};
    assign buf_din   = din_q;
    assign arr_valid = buf_read;
    assign busy      = (state_q != IDLE);

endmodule
